// File: rtl/csb_seq.sv
// csb_seq: command sequencer. Pops 6-word commands from a show-ahead FIFO,
// validates them, and drives the conv/maxpool/avepool engines one
// output-channel chunk of PAR channels at a time, counting commands to the end.
module csb_seq #(
  parameter int PAR    = 16,
  parameter int CNT_W  = 16,
  parameter int NCMD_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_en,
  input  logic              abort,
  input  logic              irq_clr,
  input  logic [NCMD_W-1:0] cmd_size,
  input  logic [31:0]       cmd,
  input  logic              cmd_empty,
  output logic              cmd_rd_en,
  output logic [2:0]        eng_start,
  input  logic [2:0]        eng_done,
  output logic [2:0]        op_type,
  output logic              padding,
  output logic [7:0]        stride_1,
  output logic [15:0]       stride_2,
  output logic [CNT_W-1:0]  i_channel_size,
  output logic [CNT_W-1:0]  o_channel_size,
  output logic [7:0]        i_kernel_size,
  output logic [7:0]        o_kernel_size,
  output logic [15:0]       op_num,
  output logic [31:0]       weight_start_addr,
  output logic [31:0]       data_start_addr,
  output logic [31:0]       writeback_addr,
  output logic [CNT_W-1:0]  chan_base,
  output logic [NCMD_W-1:0] cmd_idx,
  output logic              op_run,
  output logic              irq,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_ISSUE, S_WAIT, S_FINISH, S_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] PAR_MASK = CNT_W'(PAR - 1);
  localparam logic [CNT_W:0]   PAR_EXT  = (CNT_W+1)'(PAR);

  state_t            state, state_d;
  logic [2:0]        word_cnt, word_cnt_d;
  logic [NCMD_W-1:0] cmd_size_q, cmd_size_d;
  logic [NCMD_W-1:0] cmd_idx_d;
  logic [CNT_W-1:0]  chan_base_d;
  logic              op_run_d, irq_d, err_d;
  logic [2:0]        eng_start_d;
  logic [2:0]        op_type_d;
  logic              padding_d;
  logic [7:0]        stride_1_d;
  logic [15:0]       stride_2_d;
  logic [CNT_W-1:0]  i_channel_size_d, o_channel_size_d;
  logic [7:0]        i_kernel_size_d, o_kernel_size_d;
  logic [15:0]       op_num_d;
  logic [31:0]       weight_start_addr_d, data_start_addr_d, writeback_addr_d;

  logic [1:0]        eng_sel;
  logic [2:0]        eng_onehot;
  logic [CNT_W:0]    next_base;
  logic [NCMD_W:0]   cmd_idx_inc;
  logic              cmd_valid;

  // Engine selection, chunk/command arithmetic (one extra bit, no wrap) and validity.
  assign eng_sel     = (op_type == 3'd4) ? 2'd1 : ((op_type == 3'd5) ? 2'd2 : 2'd0);
  assign eng_onehot  = 3'b001 << eng_sel;
  assign next_base   = {1'b0, chan_base} + PAR_EXT;
  assign cmd_idx_inc = {1'b0, cmd_idx} + {{NCMD_W{1'b0}}, 1'b1};
  assign cmd_valid   = (op_type >= 3'd1) && (op_type <= 3'd5) &&
                       (o_channel_size != '0) && ((o_channel_size & PAR_MASK) == '0);
  assign cmd_rd_en   = (state == S_FETCH) && !cmd_empty;

  // Next-state and next-output logic; abort overrides every transition.
  always_comb begin
    state_d             = state;
    word_cnt_d          = word_cnt;
    cmd_size_d          = cmd_size_q;
    cmd_idx_d           = cmd_idx;
    chan_base_d         = chan_base;
    op_run_d            = op_run;
    irq_d               = irq;
    err_d               = err;
    eng_start_d         = 3'b000;
    op_type_d           = op_type;
    padding_d           = padding;
    stride_1_d          = stride_1;
    stride_2_d          = stride_2;
    i_channel_size_d    = i_channel_size;
    o_channel_size_d    = o_channel_size;
    i_kernel_size_d     = i_kernel_size;
    o_kernel_size_d     = o_kernel_size;
    op_num_d            = op_num;
    weight_start_addr_d = weight_start_addr;
    data_start_addr_d   = data_start_addr;
    writeback_addr_d    = writeback_addr;
    if (abort) begin
      state_d    = S_IDLE;
      op_run_d   = 1'b0;
      word_cnt_d = 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_en) begin
            if (cmd_size != '0) begin
              cmd_size_d = cmd_size;
              cmd_idx_d  = '0;
              word_cnt_d = 3'd0;
              op_run_d   = 1'b1;
              state_d    = S_FETCH;
            end else begin
              irq_d   = 1'b1;
              state_d = S_FINISH;
            end
          end
        end
        S_FETCH: begin
          if (!cmd_empty) begin
            case (word_cnt)
              3'd0: begin
                op_type_d  = cmd[2:0];
                padding_d  = cmd[3];
                stride_1_d = cmd[15:8];
                stride_2_d = cmd[31:16];
              end
              3'd1: begin
                i_channel_size_d = CNT_W'(cmd[15:0]);
                o_channel_size_d = CNT_W'(cmd[31:16]);
              end
              3'd2: begin
                i_kernel_size_d = cmd[7:0];
                o_kernel_size_d = cmd[15:8];
                op_num_d        = cmd[31:16];
              end
              3'd3: weight_start_addr_d = cmd;
              3'd4: data_start_addr_d   = cmd;
              3'd5: writeback_addr_d    = cmd;
              default: ;
            endcase
            word_cnt_d = word_cnt + 3'd1;
            if (word_cnt == 3'd5) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (cmd_valid) begin
            chan_base_d = '0;
            eng_start_d = eng_onehot;
            state_d     = S_ISSUE;
          end else begin
            irq_d    = 1'b1;
            err_d    = 1'b1;
            op_run_d = 1'b0;
            state_d  = S_ERROR;
          end
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (eng_done[eng_sel]) begin
            if (next_base < {1'b0, o_channel_size}) begin
              chan_base_d = next_base[CNT_W-1:0];
              eng_start_d = eng_onehot;
              state_d     = S_ISSUE;
            end else if (cmd_idx_inc == {1'b0, cmd_size_q}) begin
              irq_d    = 1'b1;
              op_run_d = 1'b0;
              state_d  = S_FINISH;
            end else begin
              cmd_idx_d  = cmd_idx_inc[NCMD_W-1:0];
              word_cnt_d = 3'd0;
              state_d    = S_FETCH;
            end
          end
        end
        S_FINISH: begin
          if (irq_clr) begin
            irq_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_ERROR: begin
          if (irq_clr) begin
            irq_d   = 1'b0;
            err_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      word_cnt          <= 3'd0;
      cmd_size_q        <= '0;
      cmd_idx           <= '0;
      chan_base         <= '0;
      op_run            <= 1'b0;
      irq               <= 1'b0;
      err               <= 1'b0;
      eng_start         <= 3'b000;
      op_type           <= 3'd0;
      padding           <= 1'b0;
      stride_1          <= 8'd0;
      stride_2          <= 16'd0;
      i_channel_size    <= '0;
      o_channel_size    <= '0;
      i_kernel_size     <= 8'd0;
      o_kernel_size     <= 8'd0;
      op_num            <= 16'd0;
      weight_start_addr <= 32'd0;
      data_start_addr   <= 32'd0;
      writeback_addr    <= 32'd0;
    end else begin
      state             <= state_d;
      word_cnt          <= word_cnt_d;
      cmd_size_q        <= cmd_size_d;
      cmd_idx           <= cmd_idx_d;
      chan_base         <= chan_base_d;
      op_run            <= op_run_d;
      irq               <= irq_d;
      err               <= err_d;
      eng_start         <= eng_start_d;
      op_type           <= op_type_d;
      padding           <= padding_d;
      stride_1          <= stride_1_d;
      stride_2          <= stride_2_d;
      i_channel_size    <= i_channel_size_d;
      o_channel_size    <= o_channel_size_d;
      i_kernel_size     <= i_kernel_size_d;
      o_kernel_size     <= o_kernel_size_d;
      op_num            <= op_num_d;
      weight_start_addr <= weight_start_addr_d;
      data_start_addr   <= data_start_addr_d;
      writeback_addr    <= writeback_addr_d;
    end
  end

endmodule
